// File: rtl/multi_voice_apu.sv
// Serially controlled multi-voice pulse APU: a UART receiver feeds a small
// command parser that programs per-voice period/control registers mixed into an unsigned DAC word.
module multi_voice_apu #(
    parameter int CHANNELS = 4,
    parameter int BAUD_DIV = 31,
    parameter int PRESCALE = 2,
    localparam int DAC_W = 4 + $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [DAC_W-1:0] dac,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_LOW, P_HIGH} p_state_t;

    rx_state_t        rx_state, rx_state_nx;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       shift, shift_nx;
    logic             byte_valid, byte_valid_nx, frame_err_nx;

    p_state_t    p_state, p_state_nx;
    logic [1:0]  hdr_chan, wr_chan;
    logic        hdr_sel, wr_sel, wr_en;
    logic [6:0]  val_lo;
    logic [13:0] wr_val;

    logic [10:0] period  [CHANNELS];
    logic [10:0] counter [CHANNELS];
    logic [2:0]  step    [CHANNELS];
    logic [3:0]  volume  [CHANNELS];
    logic [1:0]  duty    [CHANNELS];
    logic        enable  [CHANNELS];
    logic [PS_W-1:0]  presc;
    logic             tick;
    logic             pat_bit;
    logic [DAC_W-1:0] amp_sum;

    // Synchronizer flops reset to the idle-high level so reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_state   <= rx_state_nx;
            rx_cnt     <= rx_cnt_nx;
            bit_idx    <= bit_idx_nx;
            shift      <= shift_nx;
            byte_valid <= byte_valid_nx;
            frame_err  <= frame_err_nx;
        end
    end

    always_comb begin
        rx_state_nx   = rx_state;
        rx_cnt_nx     = rx_cnt + CNT_W'(1);
        bit_idx_nx    = bit_idx;
        shift_nx      = shift;
        byte_valid_nx = 1'b0;
        frame_err_nx  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nx = '0;
                if (rx_prev && !rx_sync) rx_state_nx = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nx   = '0;
                    bit_idx_nx  = '0;
                    rx_state_nx = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nx  = '0;
                    shift_nx   = {rx_sync, shift[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) rx_state_nx = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nx = '0;
                    if (rx_sync) begin
                        byte_valid_nx = 1'b1;
                        rx_state_nx   = RX_IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        rx_state_nx  = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_nx = '0;
                if (rx_sync) rx_state_nx = RX_IDLE;
            end
            default: rx_state_nx = RX_IDLE;
        endcase
    end

    // Any header restarts the sequence, so a lost byte can never misroute later writes.
    always_comb begin
        p_state_nx = p_state;
        if (byte_valid) begin
            if (shift[7]) begin
                p_state_nx = P_LOW;
            end else begin
                case (p_state)
                    P_LOW:   p_state_nx = P_HIGH;
                    P_HIGH:  p_state_nx = P_IDLE;
                    default: p_state_nx = P_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_state  <= P_IDLE;
            hdr_chan <= '0;
            hdr_sel  <= 1'b0;
            val_lo   <= '0;
            wr_en    <= 1'b0;
            wr_chan  <= '0;
            wr_sel   <= 1'b0;
            wr_val   <= '0;
        end else begin
            p_state <= p_state_nx;
            wr_en   <= 1'b0;
            if (byte_valid) begin
                if (shift[7]) begin
                    hdr_chan <= shift[1:0];
                    hdr_sel  <= shift[4];
                end else if (p_state == P_LOW) begin
                    val_lo <= shift[6:0];
                end else if (p_state == P_HIGH) begin
                    wr_en   <= 1'b1;
                    wr_chan <= hdr_chan;
                    wr_sel  <= hdr_sel;
                    wr_val  <= {shift[6:0], val_lo};
                end
            end
        end
    end

    assign tick = (presc == PS_LAST);

    // Reload reads the period register, so a new period only lands at the next reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                period[i]  <= '0;
                counter[i] <= '0;
                step[i]    <= '0;
                volume[i]  <= '0;
                duty[i]    <= '0;
                enable[i]  <= 1'b0;
            end
        end else begin
            presc <= tick ? '0 : presc + PS_W'(1);
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && int'(wr_chan) == i) begin
                    if (wr_sel) begin
                        enable[i] <= wr_val[6];
                        duty[i]   <= wr_val[5:4];
                        volume[i] <= wr_val[3:0];
                    end else begin
                        period[i] <= wr_val[10:0];
                    end
                end
                if (tick) begin
                    if (counter[i] == 11'd0) begin
                        counter[i] <= period[i];
                        if (period[i] >= 11'd8) step[i] <= step[i] + 3'd1;
                    end else begin
                        counter[i] <= counter[i] - 11'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        amp_sum = '0;
        pat_bit = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (duty[i])
                2'd0:    pat_bit = (step[i] == 3'd7);
                2'd1:    pat_bit = (step[i] >= 3'd6);
                2'd2:    pat_bit = step[i][2];
                default: pat_bit = (step[i] <= 3'd5);
            endcase
            if (enable[i] && period[i] >= 11'd8 && pat_bit)
                amp_sum = amp_sum + DAC_W'(volume[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) dac <= '0;
        else       dac <= amp_sum;
    end

endmodule

// File: tb/tb_multi_voice_apu.sv
// Self-checking bench for multi_voice_apu: drives UART commands and checks
// the DAC tone levels/durations against timing derived from the voice rules.
module tb_multi_voice_apu;

    localparam int CH    = 4;
    localparam int BAUD  = 31;
    localparam int PRE   = 2;
    localparam int DW    = 4 + $clog2(CH);
    localparam int LIMIT = 5000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic [DW-1:0] dac;
    logic          frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int fe_count = 0;
    int high_steps [4] = '{1, 2, 4, 6};

    multi_voice_apu #(.CHANNELS(CH), .BAUD_DIV(BAUD), .PRESCALE(PRE)) dut (
        .clk(clk), .reset(reset), .rx(rx), .dac(dac), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) fe_count++;

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
    endtask

    task automatic write_reg(input int ch, input bit ctrl, input int value);
        logic [7:0] hdr;
        logic [7:0] lo;
        logic [7:0] hi;
        hdr = 8'h80 | (ctrl ? 8'h10 : 8'h00) | 8'(ch & 3);
        lo  = 8'(value & 8'h7F);
        hi  = 8'((value >> 7) & 8'h7F);
        send_byte(hdr, 1'b1);
        send_byte(lo, 1'b1);
        send_byte(hi, 1'b1);
    endtask

    // Waits for a falling edge to zero, then measures one full low and high span.
    task automatic measure_tone(output int lo_len, output int hi_len,
                                output logic [DW-1:0] hi_val, output bit ok);
        int t;
        ok = 1'b1; lo_len = 0; hi_len = 0; hi_val = '0; t = 0;
        while (dac == 0 && t < LIMIT) begin @(negedge clk); t++; end
        while (dac != 0 && t < 2 * LIMIT) begin @(negedge clk); t++; end
        if (t >= 2 * LIMIT) begin ok = 1'b0; return; end
        while (dac == 0 && lo_len < LIMIT) begin @(negedge clk); lo_len++; end
        hi_val = dac;
        while (dac == hi_val && hi_len < LIMIT) begin @(negedge clk); hi_len++; end
        if (lo_len >= LIMIT || hi_len >= LIMIT) ok = 1'b0;
    endtask

    task automatic check_tone(input string name, input int p, input int duty_sel, input int vol);
        int lo, hi, exp_lo, exp_hi;
        logic [DW-1:0] v;
        bit ok;
        exp_hi = high_steps[duty_sel] * (p + 1) * PRE;
        exp_lo = (8 - high_steps[duty_sel]) * (p + 1) * PRE;
        measure_tone(lo, hi, v, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("[TB] FAIL %s_timeout: tone edges not seen (lo=%0d hi=%0d)", name, lo, hi); end
        n_cmp++;
        if (lo !== exp_lo) begin n_err++; $display("[TB] FAIL %s_low_len: got %0d expected %0d", name, lo, exp_lo); end
        n_cmp++;
        if (hi !== exp_hi) begin n_err++; $display("[TB] FAIL %s_high_len: got %0d expected %0d", name, hi, exp_hi); end
        n_cmp++;
        if (v !== DW'(vol)) begin n_err++; $display("[TB] FAIL %s_level: got %0d expected %0d", name, v, vol); end
    endtask

    task automatic test_reset();
        int bad_dac, fe0;
        reset = 1'b1; rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fe0 = fe_count; bad_dac = 0;
        repeat (1000) begin
            @(negedge clk);
            if (dac !== '0) bad_dac++;
        end
        n_cmp++;
        if (bad_dac !== 0) begin n_err++; $display("[TB] FAIL reset_dac: %0d nonzero cycles, expected 0", bad_dac); end
        n_cmp++;
        if (fe_count - fe0 !== 0) begin n_err++; $display("[TB] FAIL reset_frame_err: %0d pulses, expected 0", fe_count - fe0); end
    endtask

    task automatic test_tone();
        write_reg(0, 1'b0, 100);
        write_reg(0, 1'b1, 'h6F);
        check_tone("tone", 100, 2, 15);
    endtask

    task automatic test_short_period();
        int maxv;
        write_reg(0, 1'b0, 5);
        write_reg(0, 1'b1, 'h6F);
        maxv = 0;
        repeat (2000) begin
            @(negedge clk);
            if (int'(dac) > maxv) maxv = int'(dac);
        end
        n_cmp++;
        if (maxv !== 0) begin n_err++; $display("[TB] FAIL short_period_silent: max dac %0d expected 0", maxv); end
        write_reg(0, 1'b0, 100);
        check_tone("resume", 100, 2, 15);
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_count;
        send_byte(8'h90, 1'b1);
        send_byte(8'h55, 1'b0);
        n_cmp++;
        if (fe_count - fe0 !== 1) begin n_err++; $display("[TB] FAIL frame_err_pulse: %0d cycles high, expected 1", fe_count - fe0); end
        send_byte(8'h6F, 1'b1);
        send_byte(8'h00, 1'b1);
        check_tone("after_frame", 100, 2, 15);
        n_cmp++;
        if (fe_count - fe0 !== 1) begin n_err++; $display("[TB] FAIL frame_err_total: %0d cycles high, expected 1", fe_count - fe0); end
    endtask

    task automatic test_resync();
        write_reg(0, 1'b1, 'h00);
        write_reg(1, 1'b0, 50);
        send_byte(8'h80, 1'b1);
        send_byte(8'h10, 1'b1);
        write_reg(1, 1'b1, 'h6F);
        check_tone("resync_ch1", 50, 2, 15);
        write_reg(1, 1'b1, 'h00);
        write_reg(0, 1'b1, 'h6F);
        check_tone("resync_ch0", 100, 2, 15);
    endtask

    task automatic test_random();
        int last_ch, ch, p, vol, d;
        last_ch = 0;
        for (int k = 0; k < 3; k++) begin
            ch  = int'($urandom_range(0, CH - 1));
            p   = int'($urandom_range(10, 200));
            vol = int'($urandom_range(1, 15));
            d   = int'($urandom_range(0, 3));
            $display("[TB] random voice ch=%0d period=%0d vol=%0d duty=%0d", ch, p, vol, d);
            write_reg(last_ch, 1'b1, 0);
            write_reg(ch, 1'b0, p);
            write_reg(ch, 1'b1, 'h40 | (d << 4) | vol);
            check_tone($sformatf("random%0d", k), p, d, vol);
            last_ch = ch;
        end
    endtask

    task automatic test_back_to_back();
        int maxv, odd;
        bit seen_full;
        // Abandon a partially received byte with reset.
        @(negedge clk) rx = 1'b0;
        repeat (3 * BAUD) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        reset = 1'b0;
        repeat (4 * BAUD) @(negedge clk);
        for (int c = 0; c < CH; c++) write_reg(c, 1'b0, 100);
        for (int c = 0; c < CH; c++) write_reg(c, 1'b1, 'h7F);
        maxv = 0; odd = 0; seen_full = 1'b0;
        repeat (4000) begin
            @(negedge clk);
            if (int'(dac) > maxv) maxv = int'(dac);
            if (int'(dac) % 15 != 0) odd++;
            if (int'(dac) == 15 * CH) seen_full = 1'b1;
        end
        n_cmp++;
        if (!seen_full) begin n_err++; $display("[TB] FAIL b2b_reach: max dac %0d, expected to reach %0d", maxv, 15 * CH); end
        n_cmp++;
        if (maxv > 15 * CH) begin n_err++; $display("[TB] FAIL b2b_max: max dac %0d, limit %0d", maxv, 15 * CH); end
        n_cmp++;
        if (odd !== 0) begin n_err++; $display("[TB] FAIL b2b_levels: %0d cycles not a multiple of 15, expected 0", odd); end
    endtask

    initial begin
        test_reset();
        test_tone();
        test_short_period();
        test_frame_err();
        test_resync();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_voice_apu.md
MULTI_VOICE_APU -- requirements
Module: multi_voice_apu

Interface
REQ-001 Parameter CHANNELS, default 4, number of pulse voices (1..4).
REQ-002 Parameter BAUD_DIV, default 31, clk cycles per serial bit.
REQ-003 Parameter PRESCALE, default 2, clk cycles per voice timer tick (>=1).
REQ-004 Derived localparam DAC_W = 4 + clog2(CHANNELS) (6 at default); not overridable.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rx  input  1  asynchronous serial data, idle high, 8N1, LSB first.
REQ-008 dac  output  DAC_W  registered unsigned sum of voice amplitudes.
REQ-009 frame_err  output  1  one-cycle pulse when a received stop bit is 0.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Receiver: start on synchronized falling edge while idle; re-check low at BAUD_DIV/2; if high, return to idle (glitch reject).
REQ-012 Receiver: sample 8 data bits and the stop bit at BAUD_DIV-cycle intervals from the start mid-point; states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 Stop bit 1: byte valid for one cycle. Stop bit 0: byte discarded, frame_err pulses once, receiver enters WAIT_HIGH until synchronized rx = 1.
REQ-014 Parser: byte with bit7=1 is a header (bits[1:0] = channel, bit4 = register select: 0 period, 1 control; other bits ignored); it always restarts the parser, even mid-command.
REQ-015 Parser: after a header, next two bytes with bit7=0 form value[6:0] then value[13:7]; the register write occurs the cycle after the second data byte is valid.
REQ-016 Data bytes received with no pending header SHALL be ignored; a header for channel >= CHANNELS SHALL complete its sequence but write nothing.
REQ-017 Period register: 11 bits = value[10:0]. Control register: volume = value[3:0], duty = value[5:4], enable = value[6].
REQ-018 Voice timer: a tick occurs every PRESCALE clk cycles (shared prescaler); on a tick, counter decrements, or if 0, reloads period and advances a 3-bit step.
REQ-019 A new period SHALL take effect only at the next reload (no mid-count glitch); control changes take effect immediately.
REQ-020 Duty patterns over step 0..7: 0 = 12.5% (step 7 high), 1 = 25% (steps 6-7), 2 = 50% (steps 4-7), 3 = 75% (steps 0-5).
REQ-021 Voice amplitude = volume when enable=1, period>=8, and pattern bit high; else 0. Period<8: amplitude 0, step frozen.
REQ-022 Step length = (period+1)*PRESCALE clk cycles; tone period = 8x that.
REQ-023 dac = registered sum of all voice amplitudes, width DAC_W, no overflow possible; one cycle latency from amplitude change.

Reset
REQ-024 While reset=1: all period/control registers 0, counters and steps 0, prescaler 0, receiver IDLE, parser idle, dac=0, frame_err=0.
REQ-025 Reset asserted mid-byte or mid-command SHALL abandon it; no register write occurs.

Verification
REQ-026 Reset 2 cycles, rx=1 -> dac=0, frame_err=0 for 1000 cycles; no writes.
REQ-027 Defaults; send 0x80,0x64,0x00 (ch0 period 100) then 0x90,0x6F,0x00 (vol 15, 50%, enable) -> dac alternates 0/15, each level 808 cycles, period 1616 cycles.
REQ-028 ch0 period 5 (0x80,0x05,0x00) with control 0x6F -> dac stays 0; then period 100 -> tone resumes after next reload.
REQ-029 Byte 0x55 with stop bit 0 -> frame_err high exactly 1 cycle; registers unchanged; next valid byte after rx returns high is received correctly.
REQ-030 Send 0x80,0x10 then header 0x91,0x6F,0x00 -> ch0 period unchanged, ch1 control = 0x6F (resync).
REQ-031 All 4 voices period 100, control 0x7F (75%, vol 15, enable), written back-to-back -> dac reaches 60 while all patterns high, never exceeds 60.
